ssram_stream_reader: RTL and testbench
======================================

# ssram_stream_reader

Read-side DMA front end for the on-board synchronous SRAM. Given a base address and byte count, it issues back-to-back single-byte reads to the SRAM port, captures each returned byte, and presents the bytes in address order on a valid/ready byte stream. Typical consumer: the QOI decoder input stage. A small internal FIFO lets it absorb consumer back-pressure without losing any byte already in flight.

## Interface
Parameters:
- `FIFO_DEPTH`, default 4: output FIFO entries. Legal values are 2..16.

Ports:
- `clk`  in  1: single clock. All state changes on the rising edge.
- `rst_n`  in  1: asynchronous, active-low reset.
- `start`  in  1: request a transfer. Sampled only in IDLE.
- `base_addr`  in  addr_t (16): first SRAM address. Latched on an accepted `start`.
- `length`  in  16: byte count. Latched on an accepted `start`. 0 = empty transfer.
- `busy`  out  1: a transfer is in progress.
- `done`  out  1: one-cycle pulse when a transfer completes.
- `out_data`  out  byte_t (8): FIFO head byte.
- `out_valid`  out  1: FIFO is non-empty.
- `out_ready`  in  1: consumer accepts. A pop occurs on `out_valid & out_ready`.
- `ram_addr`  out  addr_t: SRAM address.
- `ram_data`  inout  byte_t: SRAM data bus. The block only samples it and always drives `'z`.
- `ram_cs`, `ram_we`, `ram_oe`  out  1 each: SRAM controls. `ram_we` is constant 0.

## Operation
- States are IDLE, READ and DRAIN.
- **IDLE**
  - `start=1` with `length!=0`: latch `base_addr` into `next_addr` and `length` into `remaining`, then go to READ.
  - `start=1` with `length==0`: pulse `done` in the next cycle and stay in IDLE. No SRAM access is made.
- **READ, issue condition**
  - A read issues in a cycle when `remaining!=0` and `fifo_count + inflight < FIFO_DEPTH`.
  - `fifo_count` is the value at the start of the cycle. A same-cycle pop is not credited.
- **READ, on each issue**
  - `ram_addr = next_addr`.
  - `next_addr` increments modulo 2^16, so 0xFFFF wraps to 0x0000.
  - `remaining` decrements.
  - `inflight` is set for the next cycle.
- **Capture:** in any cycle with `inflight=1`, `ram_data` is written into the FIFO at the closing edge.
- **SRAM controls**
  - `ram_cs` and `ram_oe` are high throughout READ and in any cycle with `inflight=1`, so the SRAM keeps driving its output register.
  - While stalled, `ram_addr` holds its last value. The resulting repeated reads are harmless and are never captured.
- **Leaving READ:** when `remaining==0` and `inflight==0`, go to DRAIN.
- **DRAIN**
  - `ram_cs=0` and `ram_oe=0`.
  - When the FIFO becomes empty (last pop handshake), go to IDLE. `done` pulses in the following cycle.
- **`start` while busy:** ignored. Latched values do not change.
- **FIFO:** circular with wrapping pointers. Overflow is impossible under the credit rule.
  - Push and pop in the same cycle leave the count unchanged.
  - Pop on empty cannot occur, because `out_valid=0`.
- **Reset values:** state IDLE, FIFO flushed, `inflight=0`. Outputs reset to `busy=0`, `done=0`, `out_valid=0`, `out_data=0`, `ram_cs=0`, `ram_oe=0`, `ram_we=0`, `ram_addr=0`.
- **Reset mid-transfer:** the transfer is abandoned, no `done` pulse is produced, and bytes still in the FIFO are discarded.

## Timing
- **SRAM read latency:** the address is presented in cycle N. The SRAM registers the data at the end of N and drives it during N+1. The block samples it at the end of N+1.
- **Start to first byte:** `start` is accepted at the edge ending cycle 0. The first read issues in cycle 1, is captured at the end of cycle 2, and `out_valid=1` from cycle 3.
- **Throughput:** with `out_ready` held high, one byte per cycle.
- **busy:** high from cycle 1 through the cycle of the last pop. Low in the cycle `done` pulses.
- **done:**
  - For `length==0`, `done=1` in cycle 1 and `busy` never rises.
  - Otherwise, `done=1` in the cycle after the final pop handshake.
- **Ordering:** bytes are output strictly in ascending address order modulo 2^16.

## Test plan
- **Basic burst:** SRAM preloaded with 0x10..0x17 at 0x0100..0x0107; `start`, `base=0x0100`, `len=8`, `out_ready=1`.
  - Required: first `out_valid` in cycle 3, then 8 consecutive beats 0x10..0x17.
  - `done` pulses the cycle after the last beat; `busy` is high over cycles 1..10.
- **Back-pressure:** same transfer with `out_ready` toggling 1/0 and one 6-cycle low stretch.
  - Required: all 8 bytes delivered in order, with no duplicate or lost byte.
  - `fifo_count + inflight` never exceeds 4.
- **Address wrap:** `base=0xFFFE`, `len=4`.
  - Required: `ram_addr` sequence 0xFFFE, 0xFFFF, 0x0000, 0x0001, with data in that order.
- **Zero length:** `start` with `len=0`.
  - Required: `done=1` in cycle 1, `ram_cs` stays 0, `busy` stays 0, `out_valid` stays 0.
- **Ignored start:** `start` pulsed with `base=0x0200` during an active `len=8` transfer.
  - Required: output sequence unchanged and exactly one `done`.
- **Reset mid-operation:** assert `rst_n=0` after 3 beats of a `len=8` transfer.
  - Required: all outputs take their reset values immediately (asynchronously), and no `done` pulse occurs.
  - A new `start` then `len=2` returns 2 correct bytes.

Source files
------------

// File: rtl/ssram_stream_reader.sv
// rtl/ssram_stream_reader.sv - SRAM burst reader feeding a byte stream through a credit-limited FIFO
module ssram_stream_reader #(
  parameter int FIFO_DEPTH = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic [15:0] base_addr,
  input  logic [15:0] length,
  output logic        busy,
  output logic        done,
  output logic [7:0]  out_data,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [15:0] ram_addr,
  inout  wire  [7:0]  ram_data,
  output logic        ram_cs,
  output logic        ram_we,
  output logic        ram_oe
);

  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int CW = $clog2(FIFO_DEPTH + 1);
  localparam logic [CW:0] DEPTH_L = (CW + 1)'(FIFO_DEPTH);

  typedef enum logic [1:0] {S_IDLE, S_READ, S_DRAIN} state_t;

  state_t          state, state_nxt;
  logic [15:0]     next_addr;
  logic [15:0]     remaining;
  logic [15:0]     addr_q;
  logic            inflight;
  logic            done_q;
  logic [7:0]      fifo_mem [FIFO_DEPTH];
  logic [PW-1:0]   wr_ptr, rd_ptr;
  logic [CW-1:0]   fifo_count;
  logic            issue, push, pop, accept, done_set, drain_done;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(FIFO_DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  // The block only listens on the SRAM data bus.
  assign ram_data = 'z;

  assign out_valid = (fifo_count != '0);
  assign pop       = out_valid & out_ready;
  assign push      = inflight;
  assign out_data  = out_valid ? fifo_mem[rd_ptr] : 8'h00;
  assign busy      = (state != S_IDLE);
  assign done      = done_q;
  assign ram_we    = 1'b0;
  assign ram_cs    = (state == S_READ) | inflight;
  assign ram_oe    = (state == S_READ) | inflight;
  // Hold the last issued address while stalled so repeated reads stay harmless.
  assign ram_addr  = issue ? next_addr : addr_q;

  // Credit rule: an issued read always has a FIFO slot waiting; same-cycle pops are not counted.
  assign issue = (state == S_READ) && (remaining != '0) &&
                 (({1'b0, fifo_count} + (CW + 1)'(inflight)) < DEPTH_L);

  // FIFO empties at the end of this cycle (no push can be pending when this is used).
  assign drain_done = (fifo_count == '0) || ((fifo_count == CW'(1)) && pop);

  // Next-state and control decode.
  always_comb begin
    state_nxt = state;
    accept    = 1'b0;
    done_set  = 1'b0;
    case (state)
      S_IDLE: begin
        if (start) begin
          if (length != '0) begin
            accept    = 1'b1;
            state_nxt = S_READ;
          end else begin
            done_set = 1'b1;
          end
        end
      end
      S_READ: begin
        if ((remaining == '0) && !inflight) begin
          if (drain_done) begin
            state_nxt = S_IDLE;
            done_set  = 1'b1;
          end else begin
            state_nxt = S_DRAIN;
          end
        end
      end
      S_DRAIN: begin
        if (drain_done) begin
          state_nxt = S_IDLE;
          done_set  = 1'b1;
        end
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  // State register and registered done pulse.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= S_IDLE;
      done_q <= 1'b0;
    end else begin
      state  <= state_nxt;
      done_q <= done_set;
    end
  end

  // Transfer bookkeeping: address walk, byte countdown, one-deep read pipeline.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      next_addr <= '0;
      remaining <= '0;
      addr_q    <= '0;
      inflight  <= 1'b0;
    end else begin
      inflight <= issue;
      if (accept) begin
        next_addr <= base_addr;
        remaining <= length;
      end else if (issue) begin
        next_addr <= next_addr + 16'd1;
        remaining <= remaining - 16'd1;
        addr_q    <= next_addr;
      end
    end
  end

  // FIFO pointers and occupancy.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_count <= '0;
    end else begin
      if (push) wr_ptr <= ptr_inc(wr_ptr);
      if (pop)  rd_ptr <= ptr_inc(rd_ptr);
      case ({push, pop})
        2'b10:   fifo_count <= fifo_count + 1'b1;
        2'b01:   fifo_count <= fifo_count - 1'b1;
        default: fifo_count <= fifo_count;
      endcase
    end
  end

  // FIFO storage captures the SRAM byte returned for the previous cycle's read.
  always_ff @(posedge clk) begin
    if (push) fifo_mem[wr_ptr] <= ram_data;
  end

endmodule

// File: tb/tb_ssram_stream_reader.sv
// tb/tb_ssram_stream_reader.sv - scoreboard bench for ssram_stream_reader
module tb_ssram_stream_reader;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic [15:0] base_addr;
  logic [15:0] length;
  logic        busy;
  logic        done;
  logic [7:0]  out_data;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] ram_addr;
  wire  [7:0]  ram_data;
  logic        ram_cs;
  logic        ram_we;
  logic        ram_oe;

  ssram_stream_reader #(.FIFO_DEPTH(4)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .base_addr(base_addr), .length(length),
    .busy(busy), .done(done), .out_data(out_data), .out_valid(out_valid),
    .out_ready(out_ready), .ram_addr(ram_addr), .ram_data(ram_data),
    .ram_cs(ram_cs), .ram_we(ram_we), .ram_oe(ram_oe)
  );

  always #5 clk = ~clk;

  // Synchronous SRAM model: address registered at the edge, data driven the following cycle.
  logic [7:0] mem [0:65535];
  logic [7:0] sram_q = 8'h00;
  always @(posedge clk) begin
    if (ram_cs && ram_oe && !ram_we) sram_q <= mem[ram_addr];
  end
  assign ram_data = sram_q;

  int tests = 0;
  int fails = 0;
  int cyc = 0;
  int t0 = 32'h7fff0000;
  int beats, dones, first_cyc, last_cyc, done_cyc, busy_first, busy_last, max_credit;
  bit busy_seen, cs_seen, valid_seen;
  logic [15:0] addr_log [$];
  logic [7:0]  exp_q [$];

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic clear_stats();
    beats = 0; dones = 0; first_cyc = -1; last_cyc = -1; done_cyc = -1;
    busy_first = -1; busy_last = -1; max_credit = 0;
    busy_seen = 0; cs_seen = 0; valid_seen = 0;
    t0 = 32'h7fff0000;
    addr_log.delete();
    exp_q.delete();
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_done"}, done, 0);
    chk({tag, "_out_valid"}, out_valid, 0);
    chk({tag, "_out_data"}, out_data, 0);
    chk({tag, "_ram_cs"}, ram_cs, 0);
    chk({tag, "_ram_oe"}, ram_oe, 0);
    chk({tag, "_ram_we"}, ram_we, 0);
    chk({tag, "_ram_addr"}, ram_addr, 0);
  endtask

  // Monitor: pops the scoreboard on every handshake and gathers timing statistics.
  always @(negedge clk) begin
    if (out_valid && out_ready) begin
      if (exp_q.size() == 0) begin
        tests++;
        fails++;
        $display("FAIL beat_unexpected: got %0h, no byte expected", out_data);
      end else begin
        chk("beat_data", out_data, exp_q.pop_front());
      end
      beats++;
      if (beats == 1) first_cyc = cyc;
      last_cyc = cyc;
    end
    if (done) begin
      dones++;
      done_cyc = cyc;
    end
    if (busy) begin
      if (!busy_seen) busy_first = cyc;
      busy_seen = 1;
      busy_last = cyc;
    end
    if (ram_cs) cs_seen = 1;
    if (out_valid) valid_seen = 1;
    if (int'(dut.fifo_count) + int'(dut.inflight) > max_credit)
      max_credit = int'(dut.fifo_count) + int'(dut.inflight);
    if (cyc > t0 && cyc <= t0 + 4) addr_log.push_back(ram_addr);
  end

  task automatic start_xfer(input logic [15:0] b, input logic [15:0] n);
    logic [15:0] a;
    clear_stats();
    for (int i = 0; i < int'(n); i++) begin
      a = b + 16'(i);
      exp_q.push_back(mem[a]);
    end
    @(posedge clk); #1;
    start = 1'b1; base_addr = b; length = n; t0 = cyc;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  // mode 0: ready held high; mode 1: toggling ready with a 6-cycle stall; mode 2: stray start mid-transfer
  task automatic run_xfer(input logic [15:0] b, input logic [15:0] n, input int mode, input int budget);
    int k;
    out_ready = (mode != 1);
    start_xfer(b, n);
    k = 0;
    while (dones == 0 && k < budget) begin
      if (mode == 1) out_ready = (k >= 4 && k < 10) ? 1'b0 : (k % 2 == 0);
      if (mode == 2) begin
        if (k == 3) begin
          start = 1'b1; base_addr = 16'h0200; length = 16'd3;
        end else begin
          start = 1'b0;
        end
      end
      @(posedge clk); #1;
      k++;
    end
    if (dones == 0) begin
      tests++;
      fails++;
      $display("FAIL done_timeout: got no done within %0d cycles, expected one", budget);
    end
    start = 1'b0;
    out_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("beat_count", beats, n);
    chk("done_count", dones, 1);
    chk("queue_empty", exp_q.size(), 0);
  endtask

  initial begin
    int k;
    rst_n = 1'b0; start = 1'b0; base_addr = '0; length = '0; out_ready = 1'b0;
    for (int i = 0; i < 8; i++) mem[16'h0100 + i] = 8'h10 + 8'(i);
    for (int i = 0; i < 8; i++) mem[16'h0200 + i] = 8'hE0 + 8'(i);
    mem[16'hFFFE] = 8'hA0; mem[16'hFFFF] = 8'hA1;
    mem[16'h0000] = 8'hA2; mem[16'h0001] = 8'hA3;
    mem[16'h0300] = 8'h5A; mem[16'h0301] = 8'hA5;
    clear_stats();

    #3;
    check_reset_outputs("por");
    @(posedge clk); @(posedge clk); #1;
    rst_n = 1'b1;

    // Basic burst
    run_xfer(16'h0100, 16'd8, 0, 60);
    chk("basic_first_valid_cyc", first_cyc - t0, 3);
    chk("basic_last_beat_cyc", last_cyc - t0, 10);
    chk("basic_done_cyc", done_cyc - t0, 11);
    chk("basic_busy_first_cyc", busy_first - t0, 1);
    chk("basic_busy_last_cyc", busy_last - t0, 10);

    // Back-pressure
    run_xfer(16'h0100, 16'd8, 1, 80);
    chk("bp_credit_le_depth", max_credit <= 4, 1);
    chk("bp_done_after_last", done_cyc - last_cyc, 1);

    // Address wrap
    run_xfer(16'hFFFE, 16'd4, 0, 40);
    chk("wrap_addr_log_size", addr_log.size(), 4);
    if (addr_log.size() == 4) begin
      chk("wrap_addr0", addr_log[0], 16'hFFFE);
      chk("wrap_addr1", addr_log[1], 16'hFFFF);
      chk("wrap_addr2", addr_log[2], 16'h0000);
      chk("wrap_addr3", addr_log[3], 16'h0001);
    end

    // Zero length
    run_xfer(16'h0100, 16'd0, 0, 10);
    chk("zero_done_cyc", done_cyc - t0, 1);
    chk("zero_busy_never", busy_seen, 0);
    chk("zero_cs_never", cs_seen, 0);
    chk("zero_valid_never", valid_seen, 0);

    // Ignored start while busy
    run_xfer(16'h0100, 16'd8, 2, 60);
    chk("ign_done_cyc", done_cyc - t0, 11);

    // Reset mid-transfer after three beats
    out_ready = 1'b1;
    start_xfer(16'h0100, 16'd8);
    k = 0;
    while (beats < 3 && k < 40) begin
      @(posedge clk); #2;
      k++;
    end
    chk("mid_beats_before_reset", beats, 3);
    chk("mid_valid_before_reset", out_valid, 1);
    rst_n = 1'b0;
    #1;
    check_reset_outputs("mid_rst");
    exp_q.delete();
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("mid_no_done", dones, 0);
    chk("mid_idle_busy", busy, 0);
    chk("mid_idle_valid", out_valid, 0);
    run_xfer(16'h0300, 16'd2, 0, 30);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #100000;
    fails++;
    $display("FAIL watchdog: simulation time limit reached, expected bench to finish");
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $fatal(1, "watchdog");
  end

endmodule
